// File: rtl/seq_comp_ctrl_pkg.sv
// Shared types and result codes for the sequential magnitude comparator.
package seq_comp_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // One-hot comparison results: bit0 A<B, bit1 A==B, bit2 A>B.
  localparam logic [2:0] LT = 3'b001;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] GT = 3'b100;

endpackage

// File: rtl/seq_comp_ctrl_comp2_slice.sv
// 2-bit unsigned magnitude comparator with one-hot result.
module comp2_slice
  import seq_comp_ctrl_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [2:0] res
);

  // Classify the pair as less, equal or greater.
  always_comb begin
    res = EQ;
    if (a > b) begin
      res = GT;
    end else if (a < b) begin
      res = LT;
    end
  end

endmodule

// File: rtl/seq_comp_ctrl.sv
// Sequential WIDTH-bit unsigned comparator: walks 2-bit slices MSB first
// and stops at the first unequal slice.
module seq_comp_ctrl
  import seq_comp_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NPAIR = WIDTH / 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [WIDTH-1:0]         a_in,
  input  logic [WIDTH-1:0]         b_in,
  output logic                     busy,
  output logic                     done,
  output logic [2:0]               out,
  output logic [$clog2(NPAIR):0]   cycles
);

  localparam int KW = (NPAIR > 1) ? $clog2(NPAIR) : 1;
  localparam int CW = $clog2(NPAIR) + 1;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [KW-1:0]    k;
  logic [1:0]       slice_a;
  logic [1:0]       slice_b;
  logic [2:0]       slice_res;
  logic             accept;
  logic             step;
  logic             finish;

  comp2_slice u_slice (
    .a   (slice_a),
    .b   (slice_b),
    .res (slice_res)
  );

  // Select operand pair [2k+1:2k] for the single slice comparator.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int unsigned i = 0; i < NPAIR; i++) begin
      if (k == KW'(i)) begin
        slice_a = a_q[2*i +: 2];
        slice_b = b_q[2*i +: 2];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic and datapath control strobes.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          accept  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_n = IDLE;
        end else if (slice_res != EQ || k == '0) begin
          // slice_res is EQ exactly when the final pair matched
          finish  = 1'b1;
          state_n = DONE;
        end else begin
          step = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operand capture, slice index, result and cycle-count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      k      <= '0;
      out    <= EQ;
      cycles <= '0;
    end else begin
      if (accept) begin
        a_q <= a_in;
        b_q <= b_in;
        k   <= KW'(NPAIR - 1);
      end
      if (step) begin
        k <= k - 1'b1;
      end
      if (finish) begin
        out    <= slice_res;
        cycles <= CW'(NPAIR) - CW'(k);
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_comp_ctrl.sv
// Scoreboard bench for seq_comp_ctrl at WIDTH=8 and WIDTH=4.
module tb_seq_comp_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0, abort8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8;
  logic [2:0] out8;
  logic [2:0] cycles8;

  logic       start4 = 1'b0, abort4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4;
  logic [2:0] out4;
  logic [1:0] cycles4;

  int checks = 0;
  int failures = 0;

  logic [5:0] q8[$];
  logic [5:0] q4[$];

  seq_comp_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .abort(abort8),
    .a_in(a8), .b_in(b8), .busy(busy8), .done(done8),
    .out(out8), .cycles(cycles8)
  );

  seq_comp_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4),
    .a_in(a4), .b_in(b4), .busy(busy4), .done(done4),
    .out(out4), .cycles(cycles4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Golden model: {out[2:0], cycles[2:0]} for a w-bit unsigned compare.
  function automatic logic [5:0] model(input logic [7:0] a, input logic [7:0] b, input int w);
    logic [7:0] x;
    logic [2:0] o;
    int         d;
    int         cyc;
    x = a ^ b;
    d = -1;
    for (int i = 0; i < w; i++) if (x[i]) d = i;
    cyc = (d < 0) ? w / 2 : (w / 2) - (d / 2);
    if (a < b)       o = 3'b001;
    else if (a == b) o = 3'b010;
    else             o = 3'b100;
    return {o, 3'(cyc)};
  endfunction

  // Result monitors: every done must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && done8) begin
      if (q8.size() == 0) begin
        check("unexpected_done8", 1, 0);
      end else begin
        logic [5:0] e;
        e = q8.pop_front();
        check("out8", out8, e[5:3]);
        check("cycles8", cycles8, e[2:0]);
        check("onehot8", $onehot(out8), 1);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done4) begin
      if (q4.size() == 0) begin
        check("unexpected_done4", 1, 0);
      end else begin
        logic [5:0] e;
        e = q4.pop_front();
        check("out4", out4, e[5:3]);
        check("cycles4", cycles4, e[2:0]);
        check("onehot4", $onehot(out4), 1);
      end
    end
  end

  task automatic wait_done8(input string tag);
    int n;
    n = 0;
    while (n < 12) begin
      @(negedge clk);
      n++;
      if (done8) break;
    end
    if (!done8) check(tag, 0, 1);
    @(posedge clk);
    #1;
  endtask

  // One comparison on the 8-bit instance, checking latency and return to idle.
  task automatic run8(input logic [7:0] a, input logic [7:0] b);
    logic [5:0] e;
    int         n;
    e = model(a, b, 8);
    a8 = a;
    b8 = b;
    start8 = 1'b1;
    q8.push_back(e);
    @(posedge clk);
    #1 start8 = 1'b0;
    n = 0;
    while (n < 12) begin
      @(negedge clk);
      n++;
      if (done8) break;
    end
    check("latency8", n, 32'(e[2:0]) + 1);
    @(posedge clk);
    #1;
    check("idle_after_done8", {busy8, done8}, 2'b00);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    check("rst_out8", out8, 3'b010);
    check("rst_cycles8", cycles8, 0);
    check("rst_out4", out4, 3'b010);
    check("rst_cycles4", cycles4, 0);
    rst_n = 1'b1;

    run8(8'hC3, 8'h43);
    run8(8'h5A, 8'h5B);
    run8(8'hA5, 8'hA5);
    run8(8'hFF, 8'hFE);
    run8(8'h80, 8'h7F);
    run8(8'h0C, 8'h08);

    // Abort in the second RUN cycle leaves the previous result intact.
    run8(8'hC3, 8'h43);
    a8 = 8'h00; b8 = 8'h01; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    @(posedge clk);
    #1 abort8 = 1'b1;
    @(posedge clk);
    #1 abort8 = 1'b0;
    check("abort_busy8", busy8, 0);
    check("abort_done8", done8, 0);
    check("abort_out8", out8, 3'b100);
    check("abort_cycles8", cycles8, 1);
    repeat (4) @(posedge clk);
    #1;

    // Abort together with start in IDLE wins.
    a8 = 8'h01; b8 = 8'h00; start8 = 1'b1; abort8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("abort_beats_start", busy8, 0);
    start8 = 1'b0; abort8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Abort during DONE is ignored.
    a8 = 8'hC3; b8 = 8'h43; start8 = 1'b1;
    q8.push_back(model(8'hC3, 8'h43, 8));
    @(posedge clk);
    #1 start8 = 1'b0;
    @(posedge clk);
    #1 abort8 = 1'b1;
    @(negedge clk);
    check("done_despite_abort", done8, 1);
    @(posedge clk);
    #1 abort8 = 1'b0;

    // Start with new operands during RUN is ignored.
    a8 = 8'h5A; b8 = 8'h5B; start8 = 1'b1;
    q8.push_back(model(8'h5A, 8'h5B, 8));
    @(posedge clk);
    #1 start8 = 1'b0;
    @(posedge clk);
    #1 start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00;
    @(posedge clk);
    #1 start8 = 1'b0;
    wait_done8("timeout_run_start");
    repeat (6) @(posedge clk);
    #1;

    // Reset in the middle of RUN discards the comparison immediately.
    a8 = 8'h5A; b8 = 8'h5B; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy8", busy8, 0);
    check("midrst_done8", done8, 0);
    check("midrst_out8", out8, 3'b010);
    check("midrst_cycles8", cycles8, 0);
    q8.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    run8(8'hC3, 8'h43);

    // Exhaustive 4-bit sweep with start held high throughout.
    start4 = 1'b1;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      logic [5:0] e;
      int         n;
      v = i[7:0];
      a4 = v[7:4];
      b4 = v[3:0];
      e = model({4'h0, v[7:4]}, {4'h0, v[3:0]}, 4);
      q4.push_back(e);
      @(posedge clk);
      n = 0;
      while (n < 10) begin
        @(negedge clk);
        n++;
        if (done4) break;
      end
      check("latency4", n, 32'(e[2:0]) + 1);
      @(posedge clk);
      #1;
    end
    start4 = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    check("q8_drained", q8.size(), 0);
    check("q4_drained", q4.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
